// File: rtl/lcm_add.sv
// Sequential least-common-multiple unit: repeatedly adds each operand to its
// own accumulator until both agree. Define LCM_ITER_CNT_EN to add the iter port.
module lcm_add (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [8:0]  a,
    input  logic [8:0]  b,
    output logic        busy,
    output logic        done,
    output logic [17:0] c,
    output logic        err
`ifdef LCM_ITER_CNT_EN
    ,
    output logic [9:0]  iter
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e      state_q;
    logic [17:0] op_a_q;
    logic [17:0] op_b_q;
    logic [17:0] ma_q;
    logic [17:0] mb_q;
    logic [17:0] c_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
`ifdef LCM_ITER_CNT_EN
    logic [9:0]  iter_q;
`endif

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, whatever the order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LCM_ITER_CNT_EN
            iter_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_a_q <= {9'd0, a};
                        op_b_q <= {9'd0, b};
                        ma_q   <= {9'd0, a};
                        mb_q   <= {9'd0, b};
`ifdef LCM_ITER_CNT_EN
                        iter_q <= '0;
`endif
                        // A zero operand has no defined LCM: finish immediately.
                        if (a == 9'd0 || b == 9'd0) begin
                            c_q    <= '0;
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (ma_q < mb_q) begin
                        ma_q <= ma_q + op_a_q;
`ifdef LCM_ITER_CNT_EN
                        iter_q <= iter_q + 10'd1;
`endif
                    end else if (mb_q < ma_q) begin
                        mb_q <= mb_q + op_b_q;
`ifdef LCM_ITER_CNT_EN
                        iter_q <= iter_q + 10'd1;
`endif
                    end else begin
                        c_q     <= ma_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign c    = c_q;
    assign err  = err_q;
`ifdef LCM_ITER_CNT_EN
    assign iter = iter_q;
`endif

endmodule

// File: tb/tb_lcm_add.sv
// Self-checking bench for lcm_add: directed vector table, random operands
// against a gcd-based reference, and hand-written corner sequences.
module tb_lcm_add;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  a;
    logic [8:0]  b;
    logic        busy;
    logic        done;
    logic [17:0] c;
    logic        err;
`ifdef LCM_ITER_CNT_EN
    logic [9:0]  iter;
`endif

    int total = 0;
    int bad   = 0;

    lcm_add dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .c     (c),
        .err   (err)
`ifdef LCM_ITER_CNT_EN
        ,
        .iter  (iter)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] va;
        logic [8:0] vb;
        int         exp_c;
        bit         exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: lcm = a*b/gcd; additions = (lcm/a - 1) + (lcm/b - 1).
    function automatic void ref_model(input int av, input int bv,
                                      output int rc, output bit rerr, output int rk);
        int x, y, t;
        if (av == 0 || bv == 0) begin
            rc = 0; rerr = 1'b1; rk = 0;
        end else begin
            x = av; y = bv;
            while (y != 0) begin
                t = x % y; x = y; y = t;
            end
            rc   = (av / x) * bv;
            rerr = 1'b0;
            rk   = rc / av + rc / bv - 2;
        end
    endfunction

    // One request: pulse start, scramble operands afterwards, wait for done.
    task automatic run_op(input string tag, input logic [8:0] av, input logic [8:0] bv,
                          input int exp_c, input bit exp_err, input int exp_lat);
        int lat;
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        @(posedge clk); #1;
        lat = 1;
        check({tag, " busy@edge1"}, {31'd0, busy}, {31'd0, !exp_err});
        start = 1'b0;
        a = 9'($urandom);
        b = 9'($urandom);
        while (!done && lat < 1100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " c"}, {14'd0, c}, exp_c);
        check({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
`ifdef LCM_ITER_CNT_EN
        check({tag, " iter"}, {22'd0, iter}, exp_err ? 0 : exp_lat - 2);
`endif
        @(posedge clk); #1;
        check({tag, " done one cycle"}, {31'd0, done}, 32'd0);
        check({tag, " busy after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int rc, rk, lat;
        bit rerr;
        logic [8:0] ra, rb;
        bit seen_done;

        vecs[0] = '{9'd4,   9'd6,   12,     1'b0, 5};
        vecs[1] = '{9'd35,  9'd15,  105,    1'b0, 10};
        vecs[2] = '{9'd5,   9'd5,   5,      1'b0, 2};
        vecs[3] = '{9'd0,   9'd7,   0,      1'b1, 1};
        vecs[4] = '{9'd3,   9'd7,   21,     1'b0, 10};
        vecs[5] = '{9'd511, 9'd510, 260610, 1'b0, 1021};
        vecs[6] = '{9'd7,   9'd0,   0,      1'b1, 1};
        vecs[7] = '{9'd1,   9'd1,   1,      1'b0, 2};
        vecs[8] = '{9'd1,   9'd511, 511,    1'b0, 512};
        vecs[9] = '{9'd0,   9'd0,   0,      1'b1, 1};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset c", {14'd0, c}, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb,
                   vecs[i].exp_c, vecs[i].exp_err, vecs[i].exp_lat);

        for (int i = 0; i < 20; i++) begin
            ra = (i % 7 == 3) ? 9'd0 : 9'($urandom_range(1, 511));
            rb = 9'($urandom_range(1, 511));
            ref_model(int'(ra), int'(rb), rc, rerr, rk);
            run_op($sformatf("rand%0d(%0d,%0d)", i, ra, rb), ra, rb, rc, rerr,
                   rerr ? 1 : rk + 2);
        end

        // Start pulsed mid-run with a different operand must be ignored.
        @(negedge clk);
        start = 1'b1; a = 9'd4; b = 9'd6;
        @(posedge clk); #1;
        lat = 1;
        start = 1'b0;
        @(posedge clk); #1; lat++;
        @(negedge clk);
        start = 1'b1; a = 9'd9;
        @(posedge clk); #1; lat++;
        start = 1'b0;
        while (!done && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("ignore latency", lat, 5);
        check("ignore c", {14'd0, c}, 12);
        repeat (3) begin
            @(posedge clk); #1;
            check("ignore no extra done", {31'd0, done}, 32'd0);
        end

        // Start held high: done every 5 edges, re-accepted on the next edge.
        @(negedge clk);
        start = 1'b1; a = 9'd2; b = 9'd3;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(posedge clk); #1;
            check($sformatf("held done@%0d", cyc), {31'd0, done}, {31'd0, (cyc % 5 == 0)});
            if (done) check($sformatf("held c@%0d", cyc), {14'd0, c}, 6);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);

        // Reset at edge 3 of a fresh run: outputs clear without a clock edge.
        @(negedge clk);
        start = 1'b1; a = 9'd4; b = 9'd6;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort c", {14'd0, c}, 32'd0);
        check("abort err", {31'd0, err}, 32'd0);
        seen_done = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("abort no done", {31'd0, seen_done}, 32'd0);

        // First start is taken on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; a = 9'd2; b = 9'd3;
        @(posedge clk); #1;
        lat = 1;
        start = 1'b0;
        while (!done && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("post-reset latency", lat, 5);
        check("post-reset c", {14'd0, c}, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
